// File: rtl/iob_nativebridge_target.sv
// Bridges a hold-until-ready external request interface onto a local
// valid/ready bus. One transaction is in flight at a time; the local side
// is given a bounded number of cycles to answer before an all-ones error
// response is returned and a sticky error flag is raised.
module iob_nativebridge_target #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_ext,
  input  logic [ADDR_W-1:0]   address_ext,
  input  logic [DATA_W-1:0]   wdata_ext,
  input  logic [DATA_W/8-1:0] wstrb_ext,
  output logic [DATA_W-1:0]   rdata_ext,
  output logic                ready_ext,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                busy,
  output logic                err,
  input  logic                err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter value at which a REQ cycle without m_ready becomes a timeout.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [7:0]          count_q;
  logic                err_q;
  logic                timeoutHit;

  // A completion in the last allowed cycle beats the timeout.
  assign timeoutHit = (state_q == REQ) && !m_ready && (count_q == TimeoutLast);

  // State register; reset aborts any transaction without a response.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, wait for completion or timeout, answer once.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_ext) state_d = REQ;
      REQ:     if (m_ready || timeoutHit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture, response latch, wait counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && valid_ext) begin
        addr_q  <= address_ext;
        wdata_q <= wdata_ext;
        wstrb_q <= wstrb_ext;
        count_q <= '0;
      end
      if (state_q == REQ) begin
        if (m_ready) begin
          rdata_q <= (wstrb_q == '0) ? m_rdata : '0;
        end else if (timeoutHit) begin
          rdata_q <= '1;
        end else begin
          count_q <= count_q + 8'd1;
        end
      end
      if (timeoutHit)   err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  // Output decode; m_valid and ready_ext come from disjoint states.
  always_comb begin
    m_valid   = 1'b0;
    ready_ext = 1'b0;
    busy      = 1'b0;
    case (state_q)
      REQ: begin
        m_valid = 1'b1;
        busy    = 1'b1;
      end
      RESP: begin
        ready_ext = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        m_valid   = 1'b0;
        ready_ext = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  assign m_address = addr_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign rdata_ext = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_iob_nativebridge_target.sv
// Bench for iob_nativebridge_target. Two instances share the stimulus: one
// with a short timeout (4) for error paths and one with the default (200)
// for long local waits; 'useLong' selects which instance is being observed.
module tb_iob_nativebridge_target;

  localparam int ShortTimeout = 4;
  localparam int LongTimeout  = 200;

  logic        clock = 1'b0;
  logic        reset;
  logic        validExt;
  logic [15:0] addressExt;
  logic [31:0] wdataExt;
  logic [3:0]  wstrbExt;
  logic [31:0] mRdata;
  logic        mReady;
  logic        errClr;

  logic [31:0] aRdataExt, bRdataExt;
  logic        aReadyExt, bReadyExt;
  logic        aMValid, bMValid;
  logic [15:0] aMAddress, bMAddress;
  logic [31:0] aMWdata, bMWdata;
  logic [3:0]  aMWstrb, bMWstrb;
  logic        aBusy, bBusy;
  logic        aErr, bErr;

  logic        useLong;
  logic [31:0] rdataExt;
  logic        readyExt;
  logic        mValid;
  logic [15:0] mAddress;
  logic [31:0] mWdata;
  logic [3:0]  mWstrb;
  logic        busy;
  logic        err;

  int checkCount = 0;
  int errorCount = 0;
  logic errExp;

  always #5 clock = ~clock;

  iob_nativebridge_target #(.DATA_W(32), .ADDR_W(16), .TIMEOUT(ShortTimeout)) dutShort (
    .clk(clock), .rst(reset), .valid_ext(validExt), .address_ext(addressExt),
    .wdata_ext(wdataExt), .wstrb_ext(wstrbExt), .rdata_ext(aRdataExt),
    .ready_ext(aReadyExt), .m_valid(aMValid), .m_address(aMAddress),
    .m_wdata(aMWdata), .m_wstrb(aMWstrb), .m_rdata(mRdata), .m_ready(mReady),
    .busy(aBusy), .err(aErr), .err_clr(errClr)
  );

  iob_nativebridge_target #(.DATA_W(32), .ADDR_W(16), .TIMEOUT(LongTimeout)) dutLong (
    .clk(clock), .rst(reset), .valid_ext(validExt), .address_ext(addressExt),
    .wdata_ext(wdataExt), .wstrb_ext(wstrbExt), .rdata_ext(bRdataExt),
    .ready_ext(bReadyExt), .m_valid(bMValid), .m_address(bMAddress),
    .m_wdata(bMWdata), .m_wstrb(bMWstrb), .m_rdata(mRdata), .m_ready(mReady),
    .busy(bBusy), .err(bErr), .err_clr(errClr)
  );

  assign rdataExt = useLong ? bRdataExt : aRdataExt;
  assign readyExt = useLong ? bReadyExt : aReadyExt;
  assign mValid   = useLong ? bMValid   : aMValid;
  assign mAddress = useLong ? bMAddress : aMAddress;
  assign mWdata   = useLong ? bMWdata   : aMWdata;
  assign mWstrb   = useLong ? bMWstrb   : aMWstrb;
  assign busy     = useLong ? bBusy     : aBusy;
  assign err      = useLong ? bErr      : aErr;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Runs one transaction. lat is the REQ cycle (1-based) in which the local
  // side answers; 0 or anything past the timeout means it never answers.
  task automatic applyStimulus(input logic [15:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input logic [31:0] localData,
                               input int lat, input logic clrDuring);
    int          limit;
    int          reqCount;
    int          expCount;
    logic        timedOut;
    logic        gotResp;
    logic [31:0] expData;
    limit    = useLong ? LongTimeout : ShortTimeout;
    timedOut = !(lat >= 1 && lat <= limit);
    expCount = timedOut ? limit : lat;
    if (timedOut)         expData = 32'hFFFF_FFFF;
    else if (wstrb == 4'h0) expData = localData;
    else                  expData = 32'h0;

    checkOutput("idle_mvalid", {31'b0, mValid}, 32'd0);
    validExt   = 1'b1;
    addressExt = addr;
    wdataExt   = wdata;
    wstrbExt   = wstrb;
    mReady     = 1'($urandom);
    mRdata     = $urandom;
    errClr     = clrDuring;
    tick;

    reqCount = 0;
    gotResp  = 1'b0;
    for (int cyc = 0; cyc < 32; cyc++) begin
      if (readyExt) begin
        gotResp = 1'b1;
        break;
      end
      if (mValid) begin
        reqCount++;
        checkOutput("req_addr", {16'b0, mAddress}, {16'b0, addr});
        checkOutput("req_wdata", mWdata, wdata);
        checkOutput("req_wstrb", {28'b0, mWstrb}, {28'b0, wstrb});
      end
      addressExt = 16'($urandom);
      wdataExt   = $urandom;
      wstrbExt   = 4'($urandom);
      mReady     = mValid && (reqCount == lat);
      mRdata     = (mValid && reqCount == lat) ? localData : $urandom;
      tick;
    end
    checkOutput("resp_seen", {31'b0, gotResp}, 32'd1);

    if (timedOut)       errExp = 1'b1;
    else if (clrDuring) errExp = 1'b0;
    checkOutput("resp_rdata", rdataExt, expData);
    checkOutput("resp_mvalid_low", {31'b0, mValid}, 32'd0);
    checkOutput("resp_busy", {31'b0, busy}, 32'd1);
    checkOutput("mvalid_cycles", 32'(reqCount), 32'(expCount));
    checkOutput("resp_err", {31'b0, err}, {31'b0, errExp});

    validExt = 1'b0;
    mReady   = 1'b0;
    tick;
    if (clrDuring) errExp = 1'b0;
    errClr = 1'b0;
    checkOutput("post_ready_low", {31'b0, readyExt}, 32'd0);
    checkOutput("post_busy_low", {31'b0, busy}, 32'd0);
    checkOutput("post_rdata_hold", rdataExt, expData);
    checkOutput("post_err", {31'b0, err}, {31'b0, errExp});
  endtask

  // One idle cycle with a stray m_ready and optional error clear.
  task automatic idleGap(input logic doClr);
    validExt = 1'b0;
    errClr   = doClr;
    mReady   = 1'($urandom);
    mRdata   = $urandom;
    tick;
    if (doClr) errExp = 1'b0;
    checkOutput("idle_err", {31'b0, err}, {31'b0, errExp});
    checkOutput("idle_busy", {31'b0, busy}, 32'd0);
    mReady = 1'b0;
    errClr = 1'b0;
  endtask

  // Reset both instances and confirm every output returns to zero.
  task automatic resetAll;
    reset    = 1'b1;
    validExt = 1'b0;
    mReady   = 1'b0;
    errClr   = 1'b0;
    tick;
    errExp = 1'b0;
    checkOutput("rst_mvalid", {31'b0, mValid}, 32'd0);
    checkOutput("rst_ready", {31'b0, readyExt}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    checkOutput("rst_rdata", rdataExt, 32'd0);
    checkOutput("rst_maddr", {16'b0, mAddress}, 32'd0);
    checkOutput("rst_mwdata", mWdata, 32'd0);
    checkOutput("rst_mwstrb", {28'b0, mWstrb}, 32'd0);
    reset = 1'b0;
  endtask

  // Start a read, then reset in the second REQ cycle: no response may follow.
  task automatic resetMidRequest;
    validExt   = 1'b1;
    addressExt = 16'h0020;
    wdataExt   = 32'h0;
    wstrbExt   = 4'h0;
    mReady     = 1'b0;
    tick;
    checkOutput("abort_req1", {31'b0, mValid}, 32'd1);
    tick;
    checkOutput("abort_req2", {31'b0, mValid}, 32'd1);
    resetAll;
    tick;
    checkOutput("abort_no_ready", {31'b0, readyExt}, 32'd0);
    checkOutput("abort_idle", {31'b0, busy}, 32'd0);
  endtask

  // Stimulus sequence: directed cases first, then randomized transactions.
  initial begin
    validExt   = 1'b0;
    addressExt = '0;
    wdataExt   = '0;
    wstrbExt   = '0;
    mRdata     = '0;
    mReady     = 1'b0;
    errClr     = 1'b0;
    errExp     = 1'b0;
    useLong    = 1'b1;
    reset      = 1'b1;
    tick;
    resetAll;

    applyStimulus(16'h0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1, 1'b0);
    idleGap(1'b0);
    applyStimulus(16'h0004, 32'h1234_5678, 4'hF, 32'hCAFE_F00D, 5, 1'b0);
    idleGap(1'b0);
    for (int n = 0; n < 12; n++) begin
      applyStimulus(16'($urandom), $urandom,
                    ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                    $urandom, int'($urandom_range(1, 8)), 1'b0);
      idleGap(1'b0);
    end

    useLong = 1'b0;
    resetAll;
    applyStimulus(16'h0100, 32'h0, 4'h0, 32'h5555_AAAA, 0, 1'b0);
    idleGap(1'b0);
    idleGap(1'b0);
    idleGap(1'b1);
    applyStimulus(16'h0104, 32'h0, 4'h0, 32'hA5A5_5A5A, ShortTimeout, 1'b0);
    idleGap(1'b0);
    applyStimulus(16'h0108, 32'h0, 4'h0, 32'h0, 0, 1'b1);
    idleGap(1'b0);
    resetMidRequest;
    applyStimulus(16'h0030, 32'h0, 4'h0, 32'h0BAD_CAFE, 2, 1'b0);
    idleGap(1'b0);
    for (int n = 0; n < 20; n++) begin
      applyStimulus(16'($urandom), $urandom,
                    ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                    $urandom, int'($urandom_range(0, 6)), 1'($urandom_range(0, 3) == 0));
      idleGap(1'($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/iob_nativebridge_target.md
IOB_NATIVEBRIDGE_TARGET -- requirements
Module: iob_nativebridge_target

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 16, address width in bits.
REQ-003 Parameter TIMEOUT, default 200, maximum REQ-state cycles before an error response; range 2..255.
REQ-004 The block SHALL have one clock, clk; reset rst is synchronous and active-high.
REQ-005 Ports SHALL be exactly:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_ext  in  1  external request valid
- address_ext  in  ADDR_W  external request address
- wdata_ext  in  DATA_W  external write data
- wstrb_ext  in  DATA_W/8  external byte strobes; all-zero means read
- rdata_ext  out  DATA_W  response read data
- ready_ext  out  1  response strobe, one cycle
- m_valid  out  1  local bus request valid
- m_address  out  ADDR_W  local bus address
- m_wdata  out  DATA_W  local bus write data
- m_wstrb  out  DATA_W/8  local bus strobes
- m_rdata  in  DATA_W  local bus read data
- m_ready  in  1  local bus completion strobe
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err

Function
REQ-006 External protocol: initiator holds valid_ext and request fields stable until ready_ext is high, then deasserts valid_ext in the next cycle.
REQ-007 FSM states SHALL be IDLE, REQ, RESP.
REQ-008 IDLE: on valid_ext=1, capture address_ext, wdata_ext and wstrb_ext into internal registers, clear the timeout counter, and go to REQ.
REQ-009 REQ: m_valid=1; m_address, m_wdata and m_wstrb SHALL come from the captured registers and stay stable.
REQ-010 REQ: on m_ready=1, go to RESP and latch the response data.
- Response data for a read (captured wstrb == 0): m_rdata.
- Response data for a write: all zeros.
REQ-011 m_ready is honoured in the first REQ cycle; m_ready outside REQ SHALL be ignored.
REQ-012 REQ timeout: the counter increments each REQ cycle without m_ready. When it reaches TIMEOUT-1 without m_ready:
- latch response data of all ones;
- set err;
- go to RESP.
REQ-013 If m_ready=1 in the timeout cycle, the normal completion SHALL win and err SHALL NOT be set.
REQ-014 RESP: ready_ext=1 for exactly one cycle, rdata_ext = latched value, m_valid=0; then go to IDLE unconditionally.
REQ-015 valid_ext is sampled only in IDLE. Minimum latency is valid_ext in cycle 0, m_valid in cycle 1, ready_ext in cycle 2 when m_ready is high in cycle 1.
REQ-016 rdata_ext SHALL hold its last latched value outside RESP.
REQ-017 ready_ext and m_valid SHALL never be high in the same cycle.
REQ-018 err_clr=1 clears err on the next edge. If a timeout sets err in the same cycle, the set SHALL win.
REQ-019 Captured request registers change only on the IDLE-to-REQ transition. Changes on address_ext/wdata_ext/wstrb_ext during REQ or RESP SHALL NOT propagate.

Reset
REQ-020 On rst=1 at a clock edge the block SHALL return to IDLE, with these values from the next cycle:
- m_valid, ready_ext, busy, err = 0;
- rdata_ext, m_address, m_wdata, m_wstrb = 0;
- timeout counter = 0.
REQ-021 Reset during REQ or RESP SHALL abort the transaction with no ready_ext issued. A valid_ext still high after reset is treated as a new request.

Verification
REQ-022 Read, zero-wait:
- Stimulus: valid_ext=1, address_ext=0x0010, wstrb_ext=0; m_ready=1 with m_rdata=0xDEADBEEF in the first REQ cycle.
- Response: m_valid high for 1 cycle with m_address=0x0010; ready_ext high in cycle 2 with rdata_ext=0xDEADBEEF; busy high for 2 cycles.
REQ-023 Write, 5-cycle local wait:
- Stimulus: address_ext=0x0004, wdata_ext=0x12345678, wstrb_ext=0xF; m_ready on the 5th REQ cycle.
- Response: m_wdata=0x12345678 and m_wstrb=0xF stable for 5 cycles; ready_ext one cycle later with rdata_ext=0; err=0.
REQ-024 Timeout with TIMEOUT=4 and m_ready held 0:
- Response: m_valid high exactly 4 cycles; then ready_ext=1 with rdata_ext=0xFFFFFFFF; err=1 and stays 1.
- Follow-up: err_clr pulse gives err=0 next cycle.
REQ-025 Timeout/ready race: m_ready=1 exactly in the TIMEOUT-1 cycle -> normal completion with m_rdata returned; err=0.
REQ-026 Reset mid-operation:
- Stimulus: rst in the 2nd REQ cycle.
- Response: m_valid=0 next cycle; no ready_ext; all outputs 0.
- Follow-up: a new read completes normally afterwards.
